// File: rtl/fwd_hazard_unit.sv
// Forwarding-select, load-use stall and redirect-flush control for the ID stage,
// with saturating event counters and a sticky stall watchdog.
module fwd_hazard_unit #(
  parameter  int NSTG      = 3,
  parameter  int LOAD_LAT  = 1,
  parameter  int FLUSH_CYC = 1,
  parameter  int MAX_STALL = 8,
  parameter  int CNT_W     = 32,
  localparam int SEL_W     = $clog2(NSTG + 1)
) (
  input  logic                clk_cpu,
  input  logic                rst_cpu,
  input  logic [4:0]          rs1_id,
  input  logic [4:0]          rs2_id,
  input  logic                rs1_re,
  input  logic                rs2_re,
  input  logic [5*NSTG-1:0]   rd_stg,
  input  logic [NSTG-1:0]     we_stg,
  input  logic [NSTG-1:0]     ld_stg,
  input  logic                redirect_ex,
  output logic [SEL_W-1:0]    fwd1_sel,
  output logic [SEL_W-1:0]    fwd2_sel,
  output logic                stall,
  output logic                bubble_ex,
  output logic                flush_if_id,
  output logic                stall_err,
  output logic [CNT_W-1:0]    perf_stall,
  output logic [CNT_W-1:0]    perf_flush,
  output logic [CNT_W-1:0]    perf_fwd
);

  localparam int         RUN_W     = $clog2(MAX_STALL + 1);
  localparam logic [1:0] FC_RELOAD = (FLUSH_CYC > 1) ? 2'(FLUSH_CYC - 2) : 2'd0;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t             state_q;
  logic [1:0]         fc_q;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   ps_q, ps_d, pf_q, pf_d, pw_q, pw_d;

  logic [NSTG-1:0]    m1, m2;
  logic [SEL_W-1:0]   sel1, sel2;
  logic               hz1, hz2, hz;
  logic               in_flush, flush_c, stall_c, bubble_c;

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_match
    logic [4:0] rd_k;
    assign rd_k      = rd_stg[5*gi +: 5];
    assign m1[gi]    = rs1_re && (rs1_id == rd_k) && we_stg[gi] && (rd_k != 5'd0);
    assign m2[gi]    = rs2_re && (rs2_id == rd_k) && we_stg[gi] && (rd_k != 5'd0);
  end

  // Scan oldest to youngest so the youngest match overwrites; returns {hazard, sel}.
  function automatic logic [SEL_W:0] pick(input logic [NSTG-1:0] m, input logic [NSTG-1:0] ld);
    logic [SEL_W:0] r;
    r = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (m[k]) begin
        if (ld[k] && (k < LOAD_LAT)) r = {1'b1, {SEL_W{1'b0}}};
        else                         r = {1'b0, SEL_W'(k + 1)};
      end
    end
    return r;
  endfunction

  assign {hz1, sel1} = pick(m1, ld_stg);
  assign {hz2, sel2} = pick(m2, ld_stg);
  assign hz          = hz1 || hz2;

  assign in_flush = (state_q == S_FLUSH);
  assign flush_c  = redirect_ex || in_flush;
  assign stall_c  = hz && !redirect_ex && !in_flush;
  assign bubble_c = flush_c || stall_c;

  always_ff @(posedge clk_cpu) begin
    if (rst_cpu) begin
      state_q <= S_IDLE;
      fc_q    <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redirect_ex && (FLUSH_CYC > 1)) begin
            state_q <= S_FLUSH;
            fc_q    <= FC_RELOAD;
          end
        end
        default: begin
          if (redirect_ex)         fc_q    <= FC_RELOAD;
          else if (fc_q == 2'd0)   state_q <= S_IDLE;
          else                     fc_q    <= fc_q - 2'd1;
        end
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic ev);
    return (ev && (c != {CNT_W{1'b1}})) ? c + 1'b1 : c;
  endfunction

  always_comb begin
    run_d = '0;
    if (stall_c) run_d = (run_q == RUN_W'(MAX_STALL)) ? run_q : run_q + 1'b1;
    err_d = err_q || (run_d == RUN_W'(MAX_STALL));
    ps_d  = sat_inc(ps_q, stall_c);
    pf_d  = sat_inc(pf_q, flush_c);
    pw_d  = sat_inc(pw_q, (sel1 != '0) || (sel2 != '0));
  end

  always_ff @(posedge clk_cpu) begin
    if (rst_cpu) begin
      run_q <= '0;
      err_q <= 1'b0;
      ps_q  <= '0;
      pf_q  <= '0;
      pw_q  <= '0;
    end else begin
      run_q <= run_d;
      err_q <= err_d;
      ps_q  <= ps_d;
      pf_q  <= pf_d;
      pw_q  <= pw_d;
    end
  end

  // Reset masks every output, including the registered ones, in the same cycle.
  assign fwd1_sel    = rst_cpu ? '0   : sel1;
  assign fwd2_sel    = rst_cpu ? '0   : sel2;
  assign stall       = rst_cpu ? 1'b0 : stall_c;
  assign bubble_ex   = rst_cpu ? 1'b0 : bubble_c;
  assign flush_if_id = rst_cpu ? 1'b0 : flush_c;
  assign stall_err   = rst_cpu ? 1'b0 : err_q;
  assign perf_stall  = rst_cpu ? '0   : ps_q;
  assign perf_flush  = rst_cpu ? '0   : pf_q;
  assign perf_fwd    = rst_cpu ? '0   : pw_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Two configurations of fwd_hazard_unit driven in parallel, checked every cycle
// against a behavioural model, plus directed scenarios with literal expectations.
module tb_fwd_hazard_unit;
  localparam int NSTG = 3;
  localparam int MAXS = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        rs1, rs2;
  logic              re1, re2;
  logic [5*NSTG-1:0] rd;
  logic [NSTG-1:0]   we, ld;
  logic              redir;

  logic [1:0]  a_s1, a_s2, b_s1, b_s2;
  logic        a_st, a_bu, a_fl, a_er, b_st, b_bu, b_fl, b_er;
  logic [31:0] a_ps, a_pf, a_pw;
  logic [3:0]  b_ps, b_pf, b_pw;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NSTG(NSTG), .LOAD_LAT(1), .FLUSH_CYC(1), .MAX_STALL(MAXS), .CNT_W(32)) dut_a (
    .clk_cpu(clk), .rst_cpu(rst), .rs1_id(rs1), .rs2_id(rs2), .rs1_re(re1), .rs2_re(re2),
    .rd_stg(rd), .we_stg(we), .ld_stg(ld), .redirect_ex(redir),
    .fwd1_sel(a_s1), .fwd2_sel(a_s2), .stall(a_st), .bubble_ex(a_bu), .flush_if_id(a_fl),
    .stall_err(a_er), .perf_stall(a_ps), .perf_flush(a_pf), .perf_fwd(a_pw));

  fwd_hazard_unit #(.NSTG(NSTG), .LOAD_LAT(2), .FLUSH_CYC(2), .MAX_STALL(MAXS), .CNT_W(4)) dut_b (
    .clk_cpu(clk), .rst_cpu(rst), .rs1_id(rs1), .rs2_id(rs2), .rs1_re(re1), .rs2_re(re2),
    .rd_stg(rd), .we_stg(we), .ld_stg(ld), .redirect_ex(redir),
    .fwd1_sel(b_s1), .fwd2_sel(b_s2), .stall(b_st), .bubble_ex(b_bu), .flush_if_id(b_fl),
    .stall_err(b_er), .perf_stall(b_ps), .perf_flush(b_pf), .perf_fwd(b_pw));

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     p_lat[2] = '{1, 2};
  int     p_fc[2]  = '{1, 2};
  longint p_max[2] = '{64'hFFFF_FFFF, 64'd15};
  int     m_frem[2];
  int     m_run[2];
  bit     m_err[2];
  longint m_ps[2], m_pf[2], m_pw[2];

  function automatic void msel(input logic [4:0] rs, input logic re, input int lat,
                               output int sel, output bit hzd);
    sel = 0;
    hzd = 1'b0;
    if (re && rs != 5'd0) begin
      for (int k = 0; k < NSTG; k++) begin
        if (we[k] && rd[5*k +: 5] == rs) begin
          if (ld[k] && k < lat) hzd = 1'b1;
          else                  sel = k + 1;
          break;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      longint g[9];
      longint e[9];
      string  nm[9];
      int s1, s2;
      bit h1, h2, inf, fl, st;
      nm = '{"fwd1_sel", "fwd2_sel", "stall", "bubble_ex", "flush_if_id",
             "stall_err", "perf_stall", "perf_flush", "perf_fwd"};
      if (i == 0) g = '{a_s1, a_s2, a_st, a_bu, a_fl, a_er, a_ps, a_pf, a_pw};
      else        g = '{b_s1, b_s2, b_st, b_bu, b_fl, b_er, b_ps, b_pf, b_pw};
      if (rst) begin
        e = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        m_frem[i] = 0; m_run[i] = 0; m_err[i] = 1'b0;
        m_ps[i] = 0;   m_pf[i] = 0;  m_pw[i] = 0;
      end else begin
        msel(rs1, re1, p_lat[i], s1, h1);
        msel(rs2, re2, p_lat[i], s2, h2);
        inf = (m_frem[i] > 0);
        fl  = redir || inf;
        st  = (h1 || h2) && !redir && !inf;
        e = '{s1, s2, st, fl || st, fl, m_err[i], m_ps[i], m_pf[i], m_pw[i]};
        if (redir)            m_frem[i] = p_fc[i] - 1;
        else if (inf)         m_frem[i]--;
        m_run[i] = st ? ((m_run[i] < MAXS) ? m_run[i] + 1 : MAXS) : 0;
        if (m_run[i] == MAXS) m_err[i] = 1'b1;
        if (st && m_ps[i] < p_max[i])                   m_ps[i]++;
        if (fl && m_pf[i] < p_max[i])                   m_pf[i]++;
        if ((s1 != 0 || s2 != 0) && m_pw[i] < p_max[i]) m_pw[i]++;
      end
      for (int f = 0; f < 9; f++)
        chk($sformatf("model %s %s", (i == 0) ? "A" : "B", nm[f]), g[f], e[f]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1 = 5'd0; rs2 = 5'd0; re1 = 1'b0; re2 = 1'b0;
    rd = '0; we = '0; ld = '0; redir = 1'b0;
  endtask

  task automatic stg(input int k, input logic [4:0] r, input logic w, input logic l);
    rd[5*k +: 5] = r;
    we[k] = w;
    ld[k] = l;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    rs1 = 5'd5; re1 = 1'b1; stg(0, 5'd5, 1'b1, 1'b0);
    cyc();
    #3;
    $display("phase reset: outputs masked while rst_cpu high");
    chk("rst A fwd1_sel", a_s1, 0);
    chk("rst B fwd1_sel", b_s1, 0);
    cyc();

    // ALU dependency, youngest stage wins
    rst = 1'b0;
    clr();
    rs1 = 5'd5; re1 = 1'b1; stg(0, 5'd5, 1'b1, 1'b0); stg(1, 5'd5, 1'b1, 1'b0);
    #3;
    $display("phase alu: rs1=5 vs EX/MEM rd=5");
    chk("alu A fwd1_sel", a_s1, 1);
    chk("alu A stall", a_st, 0);
    chk("alu B fwd1_sel", b_s1, 1);
    cyc();
    chk("alu A perf_fwd", a_pw, 1);

    // load-use: load to x7 walks EX -> MEM -> WB
    clr();
    rs2 = 5'd7; re2 = 1'b1; stg(0, 5'd7, 1'b1, 1'b1);
    #3;
    $display("phase load-use: load x7 in EX");
    chk("ld EX A stall", a_st, 1);
    chk("ld EX A bubble_ex", a_bu, 1);
    chk("ld EX A fwd2_sel", a_s2, 0);
    chk("ld EX B stall", b_st, 1);
    cyc();
    stg(0, 5'd0, 1'b0, 1'b0); stg(1, 5'd7, 1'b1, 1'b1);
    #3;
    $display("phase load-use: load x7 in MEM");
    chk("ld MEM A stall", a_st, 0);
    chk("ld MEM A fwd2_sel", a_s2, 2);
    chk("ld MEM B stall", b_st, 1);
    chk("ld MEM B fwd2_sel", b_s2, 0);
    cyc();
    stg(1, 5'd0, 1'b0, 1'b0); stg(2, 5'd7, 1'b1, 1'b1);
    #3;
    $display("phase load-use: load x7 in WB");
    chk("ld WB B stall", b_st, 0);
    chk("ld WB B fwd2_sel", b_s2, 3);
    cyc();
    chk("ld B perf_stall", b_ps, 2);
    chk("ld A perf_stall", a_ps, 1);

    // redirect coincident with a load-use hazard
    clr();
    rs2 = 5'd7; re2 = 1'b1; stg(0, 5'd7, 1'b1, 1'b1); redir = 1'b1;
    #3;
    $display("phase redirect: redirect with load-use pending");
    chk("rd A stall", a_st, 0);
    chk("rd A flush_if_id", a_fl, 1);
    chk("rd B stall", b_st, 0);
    chk("rd B flush_if_id", b_fl, 1);
    cyc();
    clr();
    #3;
    chk("rd2 A flush_if_id", a_fl, 0);
    chk("rd2 B flush_if_id", b_fl, 1);
    chk("rd2 B bubble_ex", b_bu, 1);
    cyc();
    #3;
    chk("rd3 B flush_if_id", b_fl, 0);
    chk("rd B perf_flush", b_pf, 2);
    chk("rd A perf_flush", a_pf, 1);

    // x0 and disabled read never forward or stall
    rs1 = 5'd0; re1 = 1'b1; stg(0, 5'd0, 1'b1, 1'b1);
    rs2 = 5'd3; re2 = 1'b0; stg(1, 5'd3, 1'b1, 1'b0);
    #3;
    $display("phase x0/disabled read");
    chk("x0 A fwd1_sel", a_s1, 0);
    chk("x0 A fwd2_sel", a_s2, 0);
    chk("x0 B stall", b_st, 0);
    cyc();

    // watchdog
    clr();
    rs1 = 5'd9; re1 = 1'b1; stg(0, 5'd9, 1'b1, 1'b1);
    $display("phase watchdog: hazard held %0d cycles", MAXS);
    repeat (MAXS - 1) cyc();
    chk("wd7 A stall_err", a_er, 0);
    cyc();
    chk("wd8 A stall_err", a_er, 1);
    chk("wd8 B stall_err", b_er, 1);
    clr();
    cyc();
    chk("wd sticky A stall_err", a_er, 1);
    rst = 1'b1;
    #3;
    $display("phase reset after watchdog");
    chk("rst2 A stall_err", a_er, 0);
    chk("rst2 A perf_stall", a_ps, 0);
    cyc();
    rst = 1'b0;
    #3;
    chk("post-rst A stall_err", a_er, 0);
    chk("post-rst A perf_fwd", a_pw, 0);
    chk("post-rst B perf_stall", b_ps, 0);

    // randomized traffic, checked by the model process
    $display("phase random: 3000 cycles");
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst   = ($urandom_range(0, 199) == 0);
      redir = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) != 0) begin
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        re1 = 1'($urandom_range(0, 7) != 0);
        re2 = 1'($urandom_range(0, 7) != 0);
        for (int k = 0; k < NSTG; k++)
          stg(k, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
    end
    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard-control unit for the pipelined RISC-V core; sits beside the ID stage. Compares ID source registers against up to NSTG downstream destination registers, selects the youngest forwarding source, stalls on load-use for a configurable load latency, sequences branch-redirect flushes over a configurable number of cycles, and keeps saturating performance counters plus a sticky stall watchdog.

## Interface
- NSTG, 3: downstream stages tracked; index 0 = EX, 1 = MEM, 2 = WB, ...; range 1..7.
- LOAD_LAT, 1: load data is forwardable only from stage index ≥ LOAD_LAT; range 1..NSTG-1.
- FLUSH_CYC, 1: cycles the flush outputs stay high per redirect; range 1..4.
- MAX_STALL, 8: consecutive stall cycles that set `stall_err`.
- CNT_W, 32: performance counter width.
- SEL_W, derived as clog2(NSTG+1); not overridable.

Ports:
- clk_cpu  in  1  core clock; all state changes on rising edge.
- rst_cpu  in  1  synchronous, active-high reset.
- rs1_id, rs2_id  in  5 each  ID source register indices.
- rs1_re, rs2_re  in  1 each  the corresponding ID source is actually read.
- rd_stg  in  5*NSTG  destination index per stage; stage k occupies bits [5k+4:5k].
- we_stg  in  NSTG  register write enable per stage.
- ld_stg  in  NSTG  the instruction in that stage is a load.
- redirect_ex  in  1  taken branch or jump resolved in EX.
- fwd1_sel, fwd2_sel  out  SEL_W each  0 = register file, k+1 = forward from stage k.
- stall  out  1  hold PC and IF/ID.
- bubble_ex  out  1  insert NOP into ID/EX.
- flush_if_id  out  1  kill IF/ID contents.
- stall_err  out  1  sticky watchdog flag.
- perf_stall, perf_flush, perf_fwd  out  CNT_W each  saturating event counters.

## Operation
- Match rule for stage k: source read enable = 1, rs == rd_stg[k], we_stg[k] = 1, rd_stg[k] != 0.
- Priority: the lowest matching k, i.e. the youngest stage, wins.
  - If the winner has ld_stg[k] = 1 and k < LOAD_LAT, it is a load-use hazard and sel = 0.
  - Otherwise sel = k+1.
  - No match gives sel = 0.
- `hz` = a load-use hazard on rs1 or rs2.
- FSM states IDLE and FLUSH; flush counter `fc` is 2 bits.
  - IDLE, redirect_ex = 1:
    - flush_if_id = 1 and bubble_ex = 1 this cycle.
    - If FLUSH_CYC > 1, go to FLUSH with fc = FLUSH_CYC-2.
  - IDLE, hz = 1 and redirect_ex = 0: stall = 1 and bubble_ex = 1.
  - IDLE, otherwise: all control outputs 0.
  - FLUSH:
    - flush_if_id = 1, bubble_ex = 1, stall = 0.
    - If fc = 0, go to IDLE; otherwise decrement fc.
    - redirect_ex in FLUSH reloads fc = FLUSH_CYC-2 and stays in FLUSH.
- Redirect beats stall in the same cycle; the hazard instruction is squashed.
- The outputs fwd*_sel are valid in every state.
- While stall or flush is active, the ID instruction is discarded or held, so sel is ignored.
- Watchdog:
  - The run counter increments on each cycle with stall = 1 and clears on stall = 0; it saturates at MAX_STALL.
  - Reaching MAX_STALL sets stall_err; only reset clears it.
- Performance counters:
  - perf_stall +1 per cycle with stall = 1.
  - perf_flush +1 per cycle with flush_if_id = 1.
  - perf_fwd +1 per cycle with any fwd*_sel != 0.
  - All three saturate at all-ones and never wrap.

## Timing
- Reset:
  - While rst_cpu = 1, all outputs are forced to 0.
  - On the next edge: FSM = IDLE, fc = 0, run counter = 0, stall_err = 0, counters = 0.
  - A reset mid-FLUSH aborts the flush immediately.
- Forward selects, stall and first-cycle flush/bubble are combinational from the current inputs, giving zero latency.
- Counters and stall_err update on the edge after the qualifying cycle.
- Load-use stall length falls out of the pipeline: a load in EX with LOAD_LAT = 2 stalls 2 cycles as the bubbles advance it.
- Flush outputs span exactly FLUSH_CYC cycles per isolated redirect.

## Test plan
- ALU dependency, NSTG = 3:
  - Stimulus: rs1_id = 5; rd EX = 5 with we; rd MEM = 5 with we.
  - Required: fwd1_sel = 1 (youngest wins), stall = 0, perf_fwd increments.
- Load-use, LOAD_LAT = 1:
  - Stimulus: rs2_id = 7; EX rd = 7 with ld = 1.
  - Required: stall = 1, bubble_ex = 1, fwd2_sel = 0.
  - Next cycle, same load now in MEM: stall = 0, fwd2_sel = 2.
- LOAD_LAT = 2:
  - Stimulus: load to x9 moves EX → MEM → WB while rs1_id = 9 is held.
  - Required: stall high 2 cycles, then fwd1_sel = 3; perf_stall = 2.
- Redirect with FLUSH_CYC = 2, coincident with a load-use hazard:
  - Required: stall = 0; flush_if_id high exactly 2 cycles; perf_flush = 2.
- x0 and disabled read:
  - Stimulus: rs1_id = 0 against rd = 0 with we; rs2_re = 0 against a matching rd.
  - Required: both sels = 0, no stall.
- Watchdog and reset:
  - Stimulus: hold hz for MAX_STALL = 8 cycles.
  - Required: stall_err = 1 after the 8th edge and remains set after hz drops.
  - Then assert rst_cpu for 1 cycle: all outputs and counters 0.
